// File: rtl/hazard_monitor_if.sv
// hazard_monitor_if
// Bundles the signals between the hazard-demo logic and the monitor.
//   y_raw, y_fix, clr          : driven by the master (logic under test / lab bench)
//   y_clean, glitch_pulse,
//   glitch_cnt, mismatch,
//   mismatch_cnt               : driven by the monitor (slave)
// CNT_W must match the CNT_W of the hazard_monitor instance attached to it.
interface hazard_monitor_if #(
  parameter int CNT_W = 8
);
  logic             y_raw;
  logic             y_fix;
  logic             clr;
  logic             y_clean;
  logic             glitch_pulse;
  logic [CNT_W-1:0] glitch_cnt;
  logic             mismatch;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output y_raw,
    output y_fix,
    output clr,
    input  y_clean,
    input  glitch_pulse,
    input  glitch_cnt,
    input  mismatch,
    input  mismatch_cnt
  );

  modport slave (
    input  y_raw,
    input  y_fix,
    input  clr,
    output y_clean,
    output glitch_pulse,
    output glitch_cnt,
    output mismatch,
    output mismatch_cnt
  );
endinterface

// File: rtl/hazard_monitor.sv
// hazard_monitor
// Clocked observer for the static-hazard demo. Synchronises the unfixed
// (y_raw) and hazard-free (y_fix) logic outputs, produces a deglitched copy
// of y_raw, and counts glitches on y_raw and y_raw/y_fix disagreement episodes.
//
// Ports
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : hazard_monitor_if.slave
//             y_raw, y_fix   - asynchronous inputs
//             clr            - synchronous clear of counters and glitch_pulse
//             y_clean        - filtered y_raw
//             glitch_pulse   - one-cycle strobe per detected glitch
//             glitch_cnt     - saturating glitch count
//             mismatch       - registered y_raw ^ y_fix (synchronised)
//             mismatch_cnt   - saturating count of disagreement episodes
//
// Parameters
//   STABLE_CYCLES : cycles a new s_raw level must persist before y_clean
//                   adopts it (>= 1)
//   CNT_W         : width of both event counters
module hazard_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_monitor_if.slave bus
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers. Channel 0 carries y_raw, channel 1 carries y_fix.
  // ---------------------------------------------------------------------------
  logic [1:0] async_in;
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;

  assign async_in = {bus.y_fix, bus.y_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= async_in[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  logic s_raw;
  logic s_fix;

  assign s_raw = sync_reg[0];
  assign s_fix = sync_reg[1];

  // ---------------------------------------------------------------------------
  // Filter FSM. run_cnt counts how many consecutive sampled cycles s_raw has
  // differed from y_clean; y_clean only moves once that run reaches
  // STABLE_CYCLES. A run that ends early is reported as a glitch.
  // ---------------------------------------------------------------------------
  logic [0:0]       state_reg;
  logic [0:0]       state_next;
  logic [RUN_W-1:0] run_cnt_reg;
  logic [RUN_W-1:0] run_cnt_next;
  logic             y_clean_reg;
  logic             y_clean_next;
  logic             glitch_det;

  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    y_clean_next = y_clean_reg;
    glitch_det   = 1'b0;

    case (state_reg)
      STABLE: begin
        if (s_raw != y_clean_reg) begin
          if (STABLE_CYCLES == 1) begin
            // No persistence required: follow s_raw directly.
            y_clean_next = s_raw;
          end else begin
            state_next   = PENDING;
            run_cnt_next = RUN_W'(1);
          end
        end
      end

      PENDING: begin
        if (s_raw != y_clean_reg) begin
          if (run_cnt_reg == RUN_LAST) begin
            // This edge samples the STABLE_CYCLES-th differing cycle.
            y_clean_next = s_raw;
            run_cnt_next = '0;
            state_next   = STABLE;
          end else begin
            run_cnt_next = run_cnt_reg + RUN_W'(1);
          end
        end else begin
          // s_raw went back before the run completed: that was a glitch.
          glitch_det   = 1'b1;
          run_cnt_next = '0;
          state_next   = STABLE;
        end
      end

      default: begin
        state_next   = STABLE;
        run_cnt_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= STABLE;
      run_cnt_reg <= '0;
      y_clean_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      y_clean_reg <= y_clean_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Disagreement tracking. An episode is counted on its first cycle only,
  // i.e. when the new difference is 1 while the registered one is still 0.
  // ---------------------------------------------------------------------------
  logic diff;
  logic mismatch_reg;
  logic mismatch_start;

  assign diff           = s_raw ^ s_fix;
  assign mismatch_start = diff & ~mismatch_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_reg <= 1'b0;
    end else begin
      mismatch_reg <= diff;
    end
  end

  // ---------------------------------------------------------------------------
  // Event counters and glitch strobe. clr wins over a same-edge event.
  // Counters stop at all-ones rather than wrapping.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] glitch_cnt_reg;
  logic [CNT_W-1:0] glitch_cnt_next;
  logic [CNT_W-1:0] mismatch_cnt_reg;
  logic [CNT_W-1:0] mismatch_cnt_next;
  logic             glitch_pulse_reg;
  logic             glitch_pulse_next;

  always_comb begin
    glitch_cnt_next   = glitch_cnt_reg;
    mismatch_cnt_next = mismatch_cnt_reg;
    glitch_pulse_next = glitch_det;

    if (glitch_det && (glitch_cnt_reg != CNT_MAX)) begin
      glitch_cnt_next = glitch_cnt_reg + CNT_W'(1);
    end
    if (mismatch_start && (mismatch_cnt_reg != CNT_MAX)) begin
      mismatch_cnt_next = mismatch_cnt_reg + CNT_W'(1);
    end

    if (bus.clr) begin
      glitch_cnt_next   = '0;
      mismatch_cnt_next = '0;
      glitch_pulse_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_cnt_reg   <= '0;
      mismatch_cnt_reg <= '0;
      glitch_pulse_reg <= 1'b0;
    end else begin
      glitch_cnt_reg   <= glitch_cnt_next;
      mismatch_cnt_reg <= mismatch_cnt_next;
      glitch_pulse_reg <= glitch_pulse_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs are driven straight from registers.
  // ---------------------------------------------------------------------------
  assign bus.y_clean      = y_clean_reg;
  assign bus.glitch_pulse = glitch_pulse_reg;
  assign bus.glitch_cnt   = glitch_cnt_reg;
  assign bus.mismatch     = mismatch_reg;
  assign bus.mismatch_cnt = mismatch_cnt_reg;

endmodule
